// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default character width,
// FIFO sizing and the transmit sequencer state encoding.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    // Transmit sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO. Pointers carry one extra wrap bit so that
// occupancy is simply wr_ptr - rd_ptr; all flags derive from registered
// pointers only. Writes while full and reads while empty are ignored here.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              wr_accept;
    logic              rd_accept;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == DEPTH);
    assign empty_o   = (count_o == '0);
    assign wr_accept = push_i && !full_o;
    assign rd_accept = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next pointer values: advance by one on an accepted access
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; resetting them discards any stored contents
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte buffer and handshake sequencer in front of uart_transmitter. Bytes are
// queued in sync_fifo; a Moore FSM loads one byte into tx_din, pulses
// tx_start for one cycle, then waits for tx_done_tick before the next byte.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy,
    output logic [DATA_W-1:0] tx_din,
    output logic              tx_start,
    input  logic              tx_done_tick
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_din_q, tx_din_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic [DATA_W-1:0] rd_data;

    sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .rd_data_o (rd_data),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Sequencer next state, byte load and pop request
    always_comb begin
        state_d  = state_q;
        tx_din_d = tx_din_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    tx_din_d = rd_data;
                    state_d  = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (tx_done_tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full) ovf_d = 1'b1;
        else if (ovf_clr)  ovf_d = 1'b0;
    end

    // Sequencer, transmit byte and overflow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tx_din_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_din_q <= tx_din_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx_start = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE);
    assign tx_din   = tx_din_q;
    assign overflow = ovf_q;

endmodule
